// File: rtl/toggle_activity_monitor_if.sv
// Control, monitored-net and readout bundle of the toggle activity monitor.
// The master side drives window control, nets and the read select; the slave side returns results.
interface toggle_activity_monitor_if #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned SEL_W = 3
) ();
    logic             start;
    logic             abort;
    logic             cont;
    logic [WIN_W-1:0] win_len;
    logic [N_CH-1:0]  sig;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, cont, win_len, sig, rd_sel,
        input  rd_data, rd_ovf, busy, done
    );

    modport slave (
        input  start, abort, cont, win_len, sig, rd_sel,
        output rd_data, rd_ovf, busy, done
    );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Per-channel switching-activity counter over a programmable cycle window.
// Publishes saturating counts and overflow flags, with a registered channel-select readout.
module toggle_activity_monitor #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned SEL_W = 3
) (
    input logic                      clk,
    input logic                      rst,
    toggle_activity_monitor_if.slave bus
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, PRIME, COUNT, LATCH} state_t;

    state_t           state;
    logic [WIN_W-1:0] win_lat;
    logic [WIN_W-1:0] win_cnt;
    logic             cont_lat;
    logic [N_CH-1:0]  prev;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  ovf;
    logic [CNT_W-1:0] pub_cnt [N_CH];
    logic [N_CH-1:0]  pub_ovf;

    logic             publish_c;
    logic             sel_ok_c;
    logic [CNT_W-1:0] pub_cnt_nxt_c [N_CH];
    logic [N_CH-1:0]  pub_ovf_nxt_c;

    // Published array after this edge; the read register samples it so a same-cycle read sees new data.
    always_comb begin
        publish_c     = (state == LATCH) && !bus.abort;
        sel_ok_c      = {1'b0, bus.rd_sel} < (SEL_W+1)'(N_CH);
        pub_ovf_nxt_c = publish_c ? ovf : pub_ovf;
        for (int i = 0; i < N_CH; i++) begin
            pub_cnt_nxt_c[i] = publish_c ? cnt[i] : pub_cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            win_lat     <= '0;
            win_cnt     <= '0;
            cont_lat    <= 1'b0;
            prev        <= '0;
            ovf         <= '0;
            pub_ovf     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]     <= '0;
                pub_cnt[i] <= '0;
            end
            bus.rd_data <= '0;
            bus.rd_ovf  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            pub_ovf  <= pub_ovf_nxt_c;
            for (int i = 0; i < N_CH; i++) begin
                pub_cnt[i] <= pub_cnt_nxt_c[i];
            end
            bus.done <= publish_c;
            if (sel_ok_c) begin
                bus.rd_data <= pub_cnt_nxt_c[IDX_W'(bus.rd_sel)];
                bus.rd_ovf  <= pub_ovf_nxt_c[IDX_W'(bus.rd_sel)];
            end else begin
                bus.rd_data <= '0;
                bus.rd_ovf  <= 1'b0;
            end

            // Abort wins over every transition, including a pending publish and a same-cycle start.
            if (bus.abort) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && (bus.win_len != '0)) begin
                            state    <= PRIME;
                            bus.busy <= 1'b1;
                            win_lat  <= bus.win_len;
                            cont_lat <= bus.cont;
                        end
                    end
                    PRIME: begin
                        prev    <= bus.sig;
                        ovf     <= '0;
                        win_cnt <= win_lat;
                        for (int i = 0; i < N_CH; i++) begin
                            cnt[i] <= '0;
                        end
                        state   <= COUNT;
                    end
                    COUNT: begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (bus.sig[i] != prev[i]) begin
                                if (cnt[i] == CNT_MAX) begin
                                    ovf[i] <= 1'b1;
                                end else begin
                                    cnt[i] <= cnt[i] + CNT_W'(1);
                                end
                            end
                        end
                        prev    <= bus.sig;
                        win_cnt <= win_cnt - WIN_W'(1);
                        if (win_cnt == WIN_W'(1)) begin
                            state <= LATCH;
                        end
                    end
                    LATCH: begin
                        prev     <= bus.sig;
                        cont_lat <= bus.cont;
                        // Continuous restart skips PRIME: prev is already refreshed here.
                        if (cont_lat && bus.cont) begin
                            ovf     <= '0;
                            win_cnt <= win_lat;
                            for (int i = 0; i < N_CH; i++) begin
                                cnt[i] <= '0;
                            end
                            state   <= COUNT;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Self-checking bench: history-based window model checked every cycle, plus directed literal checks.
module tb_toggle_activity_monitor;
    localparam int N_CH  = 8;
    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int SEL_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int HN    = 8192;

    logic clk;
    logic rst;

    toggle_activity_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SEL_W(SEL_W)) bus ();

    toggle_activity_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: keeps the sampled net history and recounts each window from it.
    logic [N_CH-1:0] hist [HN];
    int  n = 0;
    bit  m_run = 0;
    bit  m_cont = 0;
    int  m_ts = 0;
    int  m_w = 0;
    int  pub_cnt [N_CH];
    bit  pub_ovf [N_CH];
    bit  e_busy, e_done;
    int  e_rd, e_ovf;

    always begin
        @(posedge clk);
        e_done = 0;
        if (rst) begin
            m_run = 0;
            for (int c = 0; c < N_CH; c++) begin
                pub_cnt[c] = 0;
                pub_ovf[c] = 0;
            end
            hist[n % HN] = '0;
        end else begin
            hist[n % HN] = bus.sig;
            if (m_run) begin
                int rel;
                rel = n - m_ts;
                if (bus.abort) begin
                    m_run = 0;
                end else if (rel >= m_w + 2 && ((rel - (m_w + 2)) % (m_w + 1)) == 0) begin
                    for (int c = 0; c < N_CH; c++) begin
                        int tog;
                        tog = 0;
                        for (int j = n - m_w; j < n; j++) begin
                            if (hist[j % HN][c] != hist[(j - 1) % HN][c]) tog++;
                        end
                        pub_cnt[c] = (tog > CMAX) ? CMAX : tog;
                        pub_ovf[c] = (tog > CMAX);
                    end
                    e_done = 1;
                    if (!(m_cont && bus.cont)) m_run = 0;
                    m_cont = bus.cont;
                end
            end else if (bus.start && !bus.abort && bus.win_len != 0) begin
                m_run  = 1;
                m_ts   = n;
                m_w    = int'(bus.win_len);
                m_cont = bus.cont;
            end
        end
        e_busy = m_run;
        if (!rst && int'(bus.rd_sel) < N_CH) begin
            e_rd  = pub_cnt[int'(bus.rd_sel)];
            e_ovf = int'(pub_ovf[int'(bus.rd_sel)]);
        end else begin
            e_rd  = 0;
            e_ovf = 0;
        end
        n++;
        #1;
        chk("busy", int'(bus.busy), int'(e_busy));
        chk("done", int'(bus.done), int'(e_done));
        chk("rd_data", int'(bus.rd_data), e_rd);
        chk("rd_ovf", int'(bus.rd_ovf), e_ovf);
    end

    task automatic next();
        @(negedge clk);
    endtask

    task automatic read_ch(input int ch, output int d, output int o);
        bus.rd_sel = SEL_W'(ch);
        next();
        d = int'(bus.rd_data);
        o = int'(bus.rd_ovf);
    endtask

    int done_at, ndone, d, o, acc;

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.cont = 0;
        bus.win_len = '0; bus.sig = '0; bus.rd_sel = '0;
        repeat (3) next();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_rd", int'(bus.rd_data), 0);
        rst = 1'b0;
        next();

        // Single shot, WIN_LEN=8
        done_at = -1; ndone = 0;
        for (int k = 0; k < 14; k++) begin
            bus.sig[0] = ~bus.sig[0];
            if (k % 2 == 1) bus.sig[1] = ~bus.sig[1];
            bus.start   = (k == 0 || k == 3);
            bus.win_len = (k == 0) ? WIN_W'(8) : WIN_W'(3);
            next();
            if (bus.done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    chk("single_busy_falls", int'(bus.busy), 0);
                end
            end
        end
        bus.start = 0;
        chk("single_done_latency", done_at, 10);
        chk("single_done_count", ndone, 1);
        read_ch(0, d, o); chk("single_ch0", d, 8);
        read_ch(1, d, o); chk("single_ch1", d, 4);
        read_ch(7, d, o); chk("single_ch7", d, 0);

        // Saturation, WIN_LEN=40
        bus.sig = '0; done_at = -1;
        for (int k = 0; k < 46; k++) begin
            bus.start   = (k == 0);
            bus.win_len = WIN_W'(40);
            bus.sig[2]  = ~bus.sig[2];
            if (k >= 5 && k < 10) bus.sig[3] = ~bus.sig[3];
            next();
            if (bus.done && done_at < 0) done_at = k;
        end
        bus.start = 0;
        chk("sat_done_latency", done_at, 42);
        read_ch(2, d, o); chk("sat_ch2", d, 15); chk("sat_ch2_ovf", o, 1);
        read_ch(3, d, o); chk("sat_ch3", d, 5);  chk("sat_ch3_ovf", o, 0);

        // Continuous, WIN_LEN=5; CONT dropped after second publish
        bus.rd_sel = '0; bus.sig = '0; bus.cont = 1; ndone = 0;
        for (int k = 0; k < 32; k++) begin
            bus.start   = (k == 0);
            bus.win_len = WIN_W'(5);
            bus.sig[0]  = ~bus.sig[0];
            next();
            if (bus.done) begin
                ndone++;
                chk("cont_done_time", k, 7 + 6 * (ndone - 1));
                chk("cont_ch0", int'(bus.rd_data), 5);
                if (ndone == 2) bus.cont = 0;
                if (ndone == 3) chk("cont_idle_after_third", int'(bus.busy), 0);
            end
        end
        bus.start = 0; bus.cont = 0;
        chk("cont_done_count", ndone, 3);

        // Abort
        bus.sig = '0; done_at = -1;
        for (int k = 0; k < 10; k++) begin
            bus.start = (k == 0); bus.win_len = WIN_W'(6);
            bus.sig[0] = ~bus.sig[0];
            next();
            if (bus.done && done_at < 0) done_at = k;
        end
        chk("abort_pre_latency", done_at, 8);
        chk("abort_pre_ch0", int'(bus.rd_data), 6);
        ndone = 0;
        for (int k = 0; k < 35; k++) begin
            bus.start = (k == 0); bus.win_len = WIN_W'(20);
            bus.abort = (k == 10);
            bus.sig[0] = ~bus.sig[0];
            next();
            if (bus.done) ndone++;
            if (k == 10) chk("abort_busy", int'(bus.busy), 0);
        end
        bus.start = 0; bus.abort = 0;
        chk("abort_no_done", ndone, 0);
        chk("abort_ch0_kept", int'(bus.rd_data), 6);
        bus.start = 1; bus.abort = 1; bus.win_len = WIN_W'(4);
        next();
        bus.start = 0; bus.abort = 0;
        chk("start_abort_idle", int'(bus.busy), 0);
        next();
        chk("start_abort_idle2", int'(bus.busy), 0);

        // Edge cases
        bus.win_len = '0; bus.start = 1;
        next();
        bus.start = 0; acc = int'(bus.busy);
        for (int k = 0; k < 5; k++) begin
            next();
            acc = acc | int'(bus.busy) | int'(bus.done);
        end
        chk("winlen0_ignored", acc, 0);
        done_at = -1;
        for (int k = 0; k < 6; k++) begin
            bus.start = (k == 0); bus.win_len = WIN_W'(1);
            next();
            if (bus.done && done_at < 0) done_at = k;
        end
        bus.start = 0;
        chk("winlen1_latency", done_at, 3);
        read_ch(N_CH, d, o); chk("rdsel_nch", d, 0); chk("rdsel_nch_ovf", o, 0);
        read_ch(15, d, o);   chk("rdsel_15", d, 0);

        // Reset mid-window
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 0); bus.win_len = WIN_W'(10);
            bus.sig = ~bus.sig;
            next();
        end
        bus.start = 0;
        rst = 1'b1;
        next();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        acc = 0;
        for (int c = 0; c < N_CH; c++) begin
            read_ch(c, d, o);
            acc = acc | d | o;
        end
        chk("rst_all_zero", acc, 0);
        rst = 1'b0;
        next();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            bus.start   = ($urandom_range(0, 9) == 0);
            bus.win_len = ($urandom_range(0, 7) == 0) ? WIN_W'($urandom_range(16, 40))
                                                      : WIN_W'($urandom_range(0, 12));
            bus.cont    = ($urandom_range(0, 3) != 0);
            bus.abort   = ($urandom_range(0, 59) == 0);
            bus.sig     = bus.sig ^ N_CH'($urandom & $urandom);
            bus.rd_sel  = SEL_W'($urandom_range(0, 15));
            rst         = ($urandom_range(0, 599) == 0);
            next();
        end
        rst = 0; bus.start = 0; bus.abort = 0; bus.cont = 0;
        repeat (2) next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
